// File: rtl/clock_edit_pkg.sv
// rtl/clock_edit_pkg.sv - shared states, cursor codes and default timings for clock_edit_controller
package clock_edit_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      EDIT_HR  = 2'd1,
      EDIT_MIN = 2'd2,
      EDIT_SEC = 2'd3
   } editState_t;

   localparam logic [2:0] CUR_NONE = 3'b000;
   localparam logic [2:0] CUR_HR   = 3'b100;
   localparam logic [2:0] CUR_MIN  = 3'b010;
   localparam logic [2:0] CUR_SEC  = 3'b001;

   localparam int DEF_HOLD_CYCLES    = 50000000;
   localparam int DEF_REPEAT_CYCLES  = 10000000;
   localparam int DEF_TIMEOUT_CYCLES = 1000000000;
   localparam int DEF_BLINK_CYCLES   = 25000000;

   function automatic editState_t nextField(input editState_t s);
      case (s)
         RUN:      return EDIT_HR;
         EDIT_HR:  return EDIT_MIN;
         EDIT_MIN: return EDIT_SEC;
         default:  return RUN;
      endcase
   endfunction

   function automatic logic [2:0] cursorOf(input editState_t s);
      case (s)
         EDIT_HR:  return CUR_HR;
         EDIT_MIN: return CUR_MIN;
         EDIT_SEC: return CUR_SEC;
         default:  return CUR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// rtl/btn_edge_repeat.sv - rising-edge detect with optional hold/repeat (CLOCK_EDIT_AUTOREPEAT_EN)
// pulse is combinational from registered history; the caller registers it.
module btn_edge_repeat #(
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000
) (
   input  logic clk,
   input  logic reset,
   input  logic level,
   input  logic enable,
   input  logic repeatEn,
   output logic pulse
);

   logic hist;
   logic edgeSeen;

   assign edgeSeen = level & ~hist;

   // History resets high so a button held through reset release gives no edge.
   always_ff @(posedge clk) begin
      if (reset) hist <= 1'b1;
      else       hist <= level;
   end

`ifdef CLOCK_EDIT_AUTOREPEAT_EN
   localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   // holdCnt == 0 means disarmed: only a fresh enabled edge arms the repeat path.
   logic [CW-1:0] holdCnt;
   logic          repeating;
   logic          repPulse;

   always_comb begin
      repPulse = 1'b0;
      if (enable && repeatEn && level && holdCnt != '0) begin
         if (repeating) repPulse = (holdCnt == CW'(REPEAT_CYCLES));
         else           repPulse = (holdCnt == CW'(HOLD_CYCLES));
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !enable || !repeatEn || !level) begin
         holdCnt   <= '0;
         repeating <= 1'b0;
      end else if (edgeSeen) begin
         holdCnt   <= CW'(1);
         repeating <= 1'b0;
      end else if (holdCnt != '0) begin
         if (repPulse) begin
            holdCnt   <= CW'(1);
            repeating <= 1'b1;
         end else begin
            holdCnt <= holdCnt + 1'b1;
         end
      end
   end

   assign pulse = enable & (edgeSeen | repPulse);
`else
   localparam int unusedCfg = HOLD_CYCLES + REPEAT_CYCLES;
   logic unusedRepeat;
   assign unusedRepeat = repeatEn;
   assign pulse = enable & edgeSeen;
`endif

endmodule

// File: rtl/clock_edit_controller.sv
// rtl/clock_edit_controller.sv - edit-mode sequencer: cursor, up/down/clr strobes, timeout, blink
// Hold-to-repeat on up/down exists only when CLOCK_EDIT_AUTOREPEAT_EN is defined.
module clock_edit_controller
   import clock_edit_pkg::*;
#(
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int BLINK_CYCLES   = DEF_BLINK_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_clr,
   output logic [2:0] cursor_pos,
   output logic       up_pulse,
   output logic       down_pulse,
   output logic       clr_pulse,
   output logic       editing,
   output logic       blink
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);

   editState_t    state, nextState;
   logic [TW-1:0] idleCnt;
   logic [BW-1:0] blinkCnt;
   logic          modeEv, clrEv, upEv, downEv;
   logic          inEdit, pairFree, activity, fieldChange, upGo, downGo;

   assign inEdit   = (state != RUN);
   assign pairFree = ~(btn_up & btn_down);

   btn_edge_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) modeBtn (
      .clk(clk), .reset(reset), .level(btn_mode), .enable(1'b1), .repeatEn(1'b0), .pulse(modeEv));
   btn_edge_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) clrBtn (
      .clk(clk), .reset(reset), .level(btn_clr), .enable(1'b1), .repeatEn(1'b0), .pulse(clrEv));
   btn_edge_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) upBtn (
      .clk(clk), .reset(reset), .level(btn_up), .enable(inEdit & pairFree), .repeatEn(1'b1), .pulse(upEv));
   btn_edge_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) downBtn (
      .clk(clk), .reset(reset), .level(btn_down), .enable(inEdit & pairFree), .repeatEn(1'b1), .pulse(downEv));

   assign activity = modeEv | clrEv | upEv | downEv;
   // A mode step swallows any up/down strobe landing in the same cycle.
   assign upGo     = upEv & ~modeEv;
   assign downGo   = downEv & ~modeEv;

   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      if (modeEv)
         nextState = nextField(state);
      else if (inEdit && !activity && idleCnt == TW'(TIMEOUT_CYCLES - 1))
         nextState = RUN;
   end

   assign fieldChange = (nextState != state);

   always_ff @(posedge clk) begin
      if (reset || nextState == RUN || fieldChange || activity) idleCnt <= '0;
      else                                                       idleCnt <= idleCnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cursor_pos <= CUR_NONE;
         editing    <= 1'b0;
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
         clr_pulse  <= 1'b0;
         blink      <= 1'b0;
         blinkCnt   <= '0;
      end else begin
         cursor_pos <= cursorOf(nextState);
         editing    <= (nextState != RUN);
         up_pulse   <= upGo;
         down_pulse <= downGo;
         clr_pulse  <= clrEv;
         // Restart the blink phase visible whenever the field or its value changes.
         if (nextState == RUN) begin
            blink    <= 1'b0;
            blinkCnt <= '0;
         end else if (fieldChange || upGo || downGo) begin
            blink    <= 1'b1;
            blinkCnt <= '0;
         end else if (blinkCnt == BW'(BLINK_CYCLES - 1)) begin
            blink    <= ~blink;
            blinkCnt <= '0;
         end else begin
            blinkCnt <= blinkCnt + 1'b1;
         end
      end
   end

endmodule
